// File: rtl/prefix_adder_sched_if.sv
// Bundle of the two request channels, the shared adder slice port and the
// response channel of prefix_adder_sched.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high. Once valid is raised, the payload stays
// stable until that transfer. Ready may depend combinationally on valid.
interface prefix_adder_sched_if #(
   parameter int OP_W  = 48,
   parameter int SEG_W = 16
);
   logic              req0_valid;
   logic              req0_ready;
   logic [OP_W-1:0]   req0_a;
   logic [OP_W-1:0]   req0_b;
   logic              req0_cin;
   logic              req1_valid;
   logic              req1_ready;
   logic [OP_W-1:0]   req1_a;
   logic [OP_W-1:0]   req1_b;
   logic              req1_cin;
   logic [SEG_W-1:0]  add_a;
   logic [SEG_W-1:0]  add_b;
   logic              add_cin;
   logic [SEG_W-1:0]  add_sum;
   logic              add_cout;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [OP_W-1:0]   rsp_sum;
   logic              rsp_cout;
   logic              rsp_id;
   logic              busy;

   // Environment side: requesters, result consumer and the shared adder.
   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      output req1_valid, req1_a, req1_b, req1_cin,
      output add_sum, add_cout, rsp_ready,
      input  req0_ready, req1_ready, add_a, add_b, add_cin,
      input  rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
   );

   // Scheduler side.
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      input  req1_valid, req1_a, req1_b, req1_cin,
      input  add_sum, add_cout, rsp_ready,
      output req0_ready, req1_ready, add_a, add_b, add_cin,
      output rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
   );
endinterface

// File: rtl/prefix_adder_sched.sv
// Shares one SEG_W-bit adder slice between two requesters: round-robin grant,
// then an OP_W-bit add as NSEG LSB-first slice cycles with a registered carry.
module prefix_adder_sched #(
   parameter int OP_W  = 48,
   parameter int SEG_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   prefix_adder_sched_if.slave bus,
   output logic [1:0]          dbg_state
);
   localparam int NSEG      = OP_W / SEG_W;
   localparam int SEG_IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int BIT_IDX_W = (OP_W > 1) ? $clog2(OP_W) : 1;
   localparam logic [SEG_IDX_W-1:0] LAST_SEG = SEG_IDX_W'(NSEG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   logic                  rr_ptr;
   logic [SEG_IDX_W-1:0]  seg;
   logic [BIT_IDX_W-1:0]  seg_base;
   logic [OP_W-1:0]       a_q;
   logic [OP_W-1:0]       b_q;
   logic [OP_W-1:0]       sum_q;
   logic                  carry_q;
   logic                  cout_q;
   logic                  id_q;
   logic                  idle;
   logic                  gnt0;
   logic                  gnt1;

   // Ready is masked by rst_n so nothing looks accepted while reset is held.
   assign idle     = rst_n && (state == IDLE);
   assign gnt0     = idle && bus.req0_valid && (!bus.req1_valid || !rr_ptr);
   assign gnt1     = idle && bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
   assign seg_base = BIT_IDX_W'(seg) * BIT_IDX_W'(SEG_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= 1'b0;
         seg     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  a_q     <= gnt1 ? bus.req1_a   : bus.req0_a;
                  b_q     <= gnt1 ? bus.req1_b   : bus.req0_b;
                  carry_q <= gnt1 ? bus.req1_cin : bus.req0_cin;
                  id_q    <= gnt1;
                  rr_ptr  <= ~gnt1;
                  seg     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               sum_q[seg_base +: SEG_W] <= bus.add_sum;
               carry_q                  <= bus.add_cout;
               if (seg == LAST_SEG) begin
                  cout_q <= bus.add_cout;
                  state  <= DONE;
               end else begin
                  seg <= seg + 1'b1;
               end
            end
            DONE: begin
               if (bus.rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.add_a      = (state == RUN) ? a_q[seg_base +: SEG_W] : '0;
   assign bus.add_b      = (state == RUN) ? b_q[seg_base +: SEG_W] : '0;
   assign bus.add_cin    = (state == RUN) && carry_q;
   assign bus.rsp_valid  = (state == DONE);
   assign bus.rsp_sum    = sum_q;
   assign bus.rsp_cout   = cout_q;
   assign bus.rsp_id     = id_q;
   assign bus.busy       = (state != IDLE);
   assign dbg_state      = state;
endmodule

// File: tb/tb_prefix_adder_sched.sv
// Bench for prefix_adder_sched: directed corner cases, then random traffic from
// both requesters, all checked by a cycle monitor against an arithmetic model.
module tb_prefix_adder_sched;
   localparam int OP_W  = 48;
   localparam int SEG_W = 16;
   localparam int NSEG  = OP_W / SEG_W;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   prefix_adder_sched_if #(.OP_W(OP_W), .SEG_W(SEG_W)) bus ();

   prefix_adder_sched #(.OP_W(OP_W), .SEG_W(SEG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Ideal shared adder slice.
   assign {bus.add_cout, bus.add_sum} =
      {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{SEG_W{1'b0}}, bus.add_cin};

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outs();
      check("reset_rsp_sum", bus.rsp_sum, 0);
      check("reset_ctl", {bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.add_a, bus.add_b,
                          bus.add_cin, bus.busy, bus.req0_ready, bus.req1_ready}, 0);
   endtask

   // ---------------- scoreboard / model ----------------
   // Entry: {id, cout, sum} = {id, a + b + cin} computed at full width.
   logic [49:0] exp_q[$];
   int          grant_log[$];
   int          cyc      = 0;
   int          acc_cyc  = 0;
   int          run_left = 0;
   int          seg_k    = 0;
   bit          pref     = 1'b0;
   bit          prev_v   = 1'b0;
   logic [47:0] cur_a, cur_b;
   logic        cur_cin;
   logic [48:0] low_mask, low_sum;
   logic        acc_id, exp_id;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         run_left = 0;
         pref     = 1'b0;
         prev_v   = 1'b0;
      end else begin
         cyc++;
         // Ready/busy follow purely from whether an op is outstanding.
         check("busy", bus.busy, (exp_q.size() != 0));
         if (exp_q.size() == 0) begin
            if (bus.req0_valid || bus.req1_valid)
               check("ready_when_idle", bus.req0_ready | bus.req1_ready, 1);
         end else begin
            check("ready_while_busy", {bus.req0_ready, bus.req1_ready}, 0);
         end

         // Slice traffic: operand slices and the running carry of the low bits.
         if (run_left > 0) begin
            low_mask = (49'd1 << (SEG_W * seg_k)) - 49'd1;
            low_sum  = {1'b0, cur_a & low_mask[47:0]} + {1'b0, cur_b & low_mask[47:0]}
                       + {48'd0, cur_cin};
            check("slice_a", bus.add_a, cur_a[seg_k*SEG_W +: SEG_W]);
            check("slice_b", bus.add_b, cur_b[seg_k*SEG_W +: SEG_W]);
            check("slice_cin", bus.add_cin, low_sum[seg_k*SEG_W]);
            run_left--;
            seg_k++;
         end else begin
            check("add_idle", {bus.add_a, bus.add_b, bus.add_cin}, 0);
         end

         if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
            check("one_grant", bus.req0_ready & bus.req1_ready, 0);
            acc_id = bus.req1_ready;
            exp_id = (bus.req0_valid && bus.req1_valid) ? pref : bus.req1_valid;
            check("grant_id", acc_id, exp_id);
            pref = !acc_id;
            grant_log.push_back(int'(acc_id));
            cur_a   = acc_id ? bus.req1_a   : bus.req0_a;
            cur_b   = acc_id ? bus.req1_b   : bus.req0_b;
            cur_cin = acc_id ? bus.req1_cin : bus.req0_cin;
            exp_q.push_back({acc_id, {1'b0, cur_a} + {1'b0, cur_b} + {48'd0, cur_cin}});
            run_left = NSEG;
            seg_k    = 0;
            acc_cyc  = cyc;
         end

         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_rsp", bus.rsp_valid, 0);
            end else begin
               if (!prev_v) check("latency", cyc - acc_cyc, NSEG + 1);
               check("rsp", {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, exp_q[0]);
               if (bus.rsp_ready) void'(exp_q.pop_front());
            end
         end
         prev_v = bus.rsp_valid && !bus.rsp_ready;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int idx, input logic v, input logic [47:0] a,
                          input logic [47:0] b, input logic c);
      if (idx == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
      end else begin
         bus.req1_valid = v; bus.req1_a = b == b ? a : a; bus.req1_b = b; bus.req1_cin = c;
      end
   endtask

   // Holds valid until the handshake, then scrambles the operands.
   task automatic drive_req(input int idx, input logic [47:0] a, input logic [47:0] b,
                            input logic c);
      int  n    = 0;
      bit  done = 0;
      set_req(idx, 1'b1, a, b, c);
      while (!done) begin
         @(negedge clk);
         if ((idx == 0) ? bus.req0_ready : bus.req1_ready) done = 1;
         else if (++n > 400) begin
            check("req_timeout", n, 0);
            done = 1;
         end
      end
      @(posedge clk);
      #1;
      set_req(idx, 1'b0, 48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 1'($urandom));
   endtask

   function automatic logic [47:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return '1;
         1:       return '0;
         default: return 48'({$urandom, $urandom});
      endcase
   endfunction

   task automatic req_loop(input int idx, input int n, input int max_gap);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
         end
         drive_req(idx, rand_op(), rand_op(), 1'($urandom));
      end
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!bus.rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rsp_valid) check("rsp_timeout", n, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || bus.busy) && n < 300);
      if (n >= 300) check("idle_timeout", n, 0);
   endtask

   // ---------------- stimulus ----------------
   bit rand_done = 0;
   int exp_order[4] = '{0, 1, 0, 1};

   initial begin
      rst_n = 1'b0;
      bus.rsp_ready = 1'b1;
      set_req(0, 1'b1, 48'd3, 48'd4, 1'b0);
      set_req(1, 1'b0, 48'd0, 48'd0, 1'b0);
      #2;
      check_reset_outs();
      bus.req0_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full carry ripple across all slices.
      drive_req(0, 48'hFFFF_FFFF_FFFF, 48'd1, 1'b0);
      wait_rsp();
      check("t1_sum", bus.rsp_sum, 48'd0);
      check("t1_cout", bus.rsp_cout, 1);
      check("t1_id", bus.rsp_id, 0);
      wait_idle();
      @(posedge clk);
      #1;

      // Carry-in propagating through two slices.
      drive_req(0, 48'h0000_FFFF_FFFF, 48'd0, 1'b1);
      wait_rsp();
      check("t2_sum", bus.rsp_sum, 48'h0001_0000_0000);
      check("t2_cout", bus.rsp_cout, 0);
      wait_idle();
      @(posedge clk);
      #1;

      // Back-pressure in DONE with the other requester waiting.
      bus.rsp_ready = 1'b0;
      drive_req(0, rand_op(), rand_op(), 1'b1);
      fork
         drive_req(1, rand_op(), rand_op(), 1'b0);
         begin
            wait_rsp();
            repeat (5) @(negedge clk);
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b1;
         end
      join
      wait_idle();
      @(posedge clk);
      #1;

      // Reset in the middle of RUN, then a lone req1 after release.
      drive_req(0, rand_op(), rand_op(), 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_req(1, 48'd5, 48'd7, 1'b0);
      wait_rsp();
      check("t5_sum", bus.rsp_sum, 48'd12);
      check("t5_id", bus.rsp_id, 1);
      wait_idle();
      @(posedge clk);
      #1;

      // Both requesters valid straight out of reset and held.
      rst_n = 1'b0;
      grant_log.delete();
      fork
         req_loop(0, 2, 0);
         req_loop(1, 2, 0);
         begin
            #2;
            check_reset_outs();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
      join
      wait_idle();
      check("t3_grants", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check($sformatf("t3_order%0d", i), grant_log[i], exp_order[i]);
      @(posedge clk);
      #1;

      // Random traffic with random consumer back-pressure.
      fork
         begin
            fork
               req_loop(0, 25, 4);
               req_loop(1, 25, 4);
            join
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
            bus.rsp_ready = 1'b1;
         end
      join
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
